regfile_scrubber: RTL and testbench
===================================

// Module: regfile_scrubber
// PURPOSE
//  Hardware clear sequencer between CPU writeback mux and register file write port.
//  On start, walks int regs $1..$31 (optionally FP $f0..$f31) writing 32'h0, one reg/cycle.
//  Holds the PC via stall while clearing; then pulses done.
//  In IDLE it is a transparent pass-through for normal CPU writeback.
// PARAMETERS
//  NUM_REGS    32  registers per file
//  ADDR_W      5   register address width; NUM_REGS == 2**ADDR_W
//  DATA_W      32  register data width
//  FIRST_ADDR  1   first int reg cleared; $0 is hardwired and skipped
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  start        in   1       request a clear pass; sampled only in IDLE
//  busy         out  1       high in INT_CLR / FP_CLR
//  stall        out  1       PC hold to CPU; equal to busy
//  done         out  1       one-cycle pulse after the last clear write
//  cpu_wr_en    in   1       CPU writeback enable (regWrite)
//  cpu_wr_addr  in   ADDR_W  CPU writeback address
//  cpu_wr_data  in   DATA_W  CPU writeback data
//  rf_wr_en     out  1       int register file write enable
//  rf_wr_addr   out  ADDR_W  int register file write address
//  rf_wr_data   out  DATA_W  int register file write data
//  fp_wr_en/fp_wr_addr/fp_wr_data out 1/ADDR_W/DATA_W  FP file port (CLEAR_FP_REGS_EN only)
// BEHAVIOUR
//  - States: IDLE, INT_CLR, FP_CLR, DONE. Registered addr counter cnt[ADDR_W-1:0].
//  - reset: state=IDLE, cnt=0, busy=stall=done=0. rf_wr_* follow cpu_wr_* (IDLE pass-through).
//    fp_wr_* = 0.
//  - IDLE: rf_wr_* = cpu_wr_* combinationally, same cycle. start=1 -> INT_CLR, cnt<=FIRST_ADDR.
//    A CPU write in the start cycle still passes through.
//  - INT_CLR: rf_wr_en=1, rf_wr_addr=cnt, rf_wr_data=0.
//    CPU writes are dropped; the CPU is stalled, so none are expected.
//    If cnt==NUM_REGS-1: -> FP_CLR with cnt<=0 when the macro is defined, else -> DONE.
//    Otherwise cnt<=cnt+1.
//  - FP_CLR: fp_wr_en=1, fp_wr_addr=cnt, fp_wr_data=0; rf_wr_en=0.
//    If cnt==NUM_REGS-1: -> DONE. Otherwise cnt<=cnt+1.
//  - DONE: done=1, busy=stall=0, rf_wr_en=0, cnt<=0 -> IDLE next cycle.
//  - Terminal compare precedes increment; cnt never wraps inside a pass.
//  - Latency, start at edge 0: int writes on cycles 1..31; done on cycle 32
//    (FP enabled: FP writes 32..63, done 64).
//  - start while not IDLE is ignored; no queuing.
//  - reset mid-pass: abort immediately -> IDLE, no done pulse, partially cleared regs left as is.
//  - start and reset together: reset wins.
// CONFIGURATION
//  CLEAR_FP_REGS_EN defined: FP_CLR state and fp_wr_* ports exist; pass clears $f0..$f31 after ints.
//  Undefined: no fp_wr_* ports, FP_CLR unreachable/omitted; INT_CLR last addr -> DONE.
// TESTING
//  1 reset, cpu_wr_en=1 addr=5 data=32'h10e -> rf_wr_en=1 addr=5 data=10e same cycle; busy=0 done=0.
//  2 start pulse 1 cycle -> rf_wr_en=1 data=0, addr 1,2,...,31 on consecutive cycles;
//    stall=1 for 31 cycles; done=1 exactly one cycle (cycle 32); then pass-through restored.
//  3 during clear, cpu_wr_en=1 addr=2 data=32'hdead -> never on rf port;
//    reg $2 reads 0 after done; start re-asserted at cycle 10 ignored.
//  4 reset asserted at clear cycle 12 -> next cycle busy=stall=0, rf_wr_en=cpu_wr_en,
//    no done; regs 1..11 zero, 12..31 unchanged.
//  5 CLEAR_FP_REGS_EN: start -> int addrs 1..31, then fp_wr_en addrs 0..31, done at cycle 64;
//    rf_wr_en=0 during FP phase.
//  6 start and cpu write same cycle in IDLE: write (addr=3 data=7) lands; clear begins next cycle;
//    $3 ends 0.

Source files
------------

// File: rtl/regfile_scrubber_if.sv
// regfile_scrubber_if
//   Bundles the scrubber's control handshake and the three register-file
//   write paths between the CPU writeback mux and the register files.
//   Parameters: ADDR_W (register address width), DATA_W (register data width).
//   Signals:
//     start                       clear request from the CPU/controller
//     busy / stall / done         scrubber status (stall holds the PC)
//     cpu_wr_en/addr/data         CPU writeback into the scrubber
//     rf_wr_en/addr/data          integer register file write port
//     fp_wr_en/addr/data          FP register file write port
//                                 (only when CLEAR_FP_REGS_EN is defined)
//   Modports:
//     master - CPU / controller side
//     slave  - the scrubber itself
// Optional feature macro: CLEAR_FP_REGS_EN
interface regfile_scrubber_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic              busy;
  logic              stall;
  logic              done;
  logic              cpu_wr_en;
  logic [ADDR_W-1:0] cpu_wr_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
`ifdef CLEAR_FP_REGS_EN
  logic              fp_wr_en;
  logic [ADDR_W-1:0] fp_wr_addr;
  logic [DATA_W-1:0] fp_wr_data;

  modport master (
    output start, cpu_wr_en, cpu_wr_addr, cpu_wr_data,
    input  busy, stall, done,
    input  rf_wr_en, rf_wr_addr, rf_wr_data,
    input  fp_wr_en, fp_wr_addr, fp_wr_data
  );

  modport slave (
    input  start, cpu_wr_en, cpu_wr_addr, cpu_wr_data,
    output busy, stall, done,
    output rf_wr_en, rf_wr_addr, rf_wr_data,
    output fp_wr_en, fp_wr_addr, fp_wr_data
  );
`else
  modport master (
    output start, cpu_wr_en, cpu_wr_addr, cpu_wr_data,
    input  busy, stall, done,
    input  rf_wr_en, rf_wr_addr, rf_wr_data
  );

  modport slave (
    input  start, cpu_wr_en, cpu_wr_addr, cpu_wr_data,
    output busy, stall, done,
    output rf_wr_en, rf_wr_addr, rf_wr_data
  );
`endif
endinterface

// File: rtl/regfile_scrubber.sv
// regfile_scrubber
//   Clear sequencer sitting between the CPU writeback mux and the register
//   file write port(s). On start it walks integer registers FIRST_ADDR..
//   NUM_REGS-1 writing zero, one register per cycle, while stalling the CPU,
//   then pulses done for one cycle. When idle it passes CPU writeback straight
//   through (combinationally, same cycle).
//   With CLEAR_FP_REGS_EN defined the pass continues over FP registers
//   0..NUM_REGS-1 on the fp_wr_* port before done.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    regfile_scrubber_if.slave (start/busy/stall/done, cpu_wr_*,
//          rf_wr_*, fp_wr_* when CLEAR_FP_REGS_EN)
// Parameters: NUM_REGS (=2**ADDR_W), ADDR_W, DATA_W, FIRST_ADDR
// Optional feature macro: CLEAR_FP_REGS_EN
module regfile_scrubber #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int FIRST_ADDR = 1
) (
  input logic               clk,
  input logic               reset,
  regfile_scrubber_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INT_CLR = 2'd1,
    FP_CLR  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(FIRST_ADDR);

  state_t            state_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic              busy_reg;
  logic              done_reg;

  // Sequencer. The terminal compare is taken before the increment so the
  // counter never wraps inside a pass. Status outputs are registered and
  // updated on the same edges as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            state_reg <= INT_CLR;
            cnt_reg   <= START_ADDR;
            busy_reg  <= 1'b1;
          end
        end
        INT_CLR: begin
          if (cnt_reg == LAST_ADDR) begin
`ifdef CLEAR_FP_REGS_EN
            state_reg <= FP_CLR;
            cnt_reg   <= '0;
`else
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
`endif
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`ifdef CLEAR_FP_REGS_EN
        FP_CLR: begin
          if (cnt_reg == LAST_ADDR) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`endif
        DONE: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_reg;
  assign bus.stall = busy_reg;
  assign bus.done  = done_reg;

  // Write-port mux. Clear writes are gated by reset so that a reset arriving
  // mid-pass aborts without touching the register addressed in that cycle.
  // CPU writes arriving during a clear are dropped (the CPU is stalled).
  always_comb begin
    bus.rf_wr_en   = bus.cpu_wr_en;
    bus.rf_wr_addr = bus.cpu_wr_addr;
    bus.rf_wr_data = bus.cpu_wr_data;
`ifdef CLEAR_FP_REGS_EN
    bus.fp_wr_en   = 1'b0;
    bus.fp_wr_addr = '0;
    bus.fp_wr_data = '0;
`endif
    case (state_reg)
      INT_CLR: begin
        bus.rf_wr_en   = ~reset;
        bus.rf_wr_addr = cnt_reg;
        bus.rf_wr_data = '0;
      end
`ifdef CLEAR_FP_REGS_EN
      FP_CLR: begin
        bus.rf_wr_en   = 1'b0;
        bus.rf_wr_addr = '0;
        bus.rf_wr_data = '0;
        bus.fp_wr_en   = ~reset;
        bus.fp_wr_addr = cnt_reg;
      end
`endif
      DONE: begin
        bus.rf_wr_en = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_scrubber.sv
// tb_regfile_scrubber
//   Directed bench for regfile_scrubber. Behavioural register-file models
//   capture every write on the rf_wr_* (and fp_wr_*) ports so final register
//   contents can be compared against hand-computed expectations.
//   Cycle numbering: start is sampled at edge 0; cycle N is the interval
//   after edge N-1.
// Optional feature macro: CLEAR_FP_REGS_EN
module tb_regfile_scrubber;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_scrubber_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_scrubber #(
    .NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_ADDR(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

`ifdef CLEAR_FP_REGS_EN
  localparam int DONE_CYC = 64;
`else
  localparam int DONE_CYC = 32;
`endif

  int tests = 0;
  int fails = 0;

  logic        preload = 1'b0;
  logic [31:0] rf_mem [32];
  logic [31:0] fp_mem [32];

  function automatic logic [31:0] pat(input int i);
    return 32'ha5a5_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] fpat(input int i);
    return 32'h5a5a_0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) begin
        rf_mem[i] <= pat(i);
        fp_mem[i] <= fpat(i);
      end
    end else begin
      if (bus.rf_wr_en) rf_mem[bus.rf_wr_addr] <= bus.rf_wr_data;
`ifdef CLEAR_FP_REGS_EN
      if (bus.fp_wr_en) fp_mem[bus.fp_wr_addr] <= bus.fp_wr_data;
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_preload();
    preload = 1'b1;
    step();
    preload = 1'b0;
  endtask

  // Drives a full pass starting from cycle 0 (start already high) and checks
  // every cycle through done and one cycle after. noise=1 drives a CPU write
  // of 32'hdead to $2 throughout and re-asserts start at cycle 10.
  task automatic run_pass(input string name, input bit noise);
    for (int c = 1; c < DONE_CYC; c++) begin
      step();
      bus.start = (noise && c == 10);
      if (noise) begin
        bus.cpu_wr_en   = 1'b1;
        bus.cpu_wr_addr = 5'd2;
        bus.cpu_wr_data = 32'hdead;
      end
      #1;
      chk($sformatf("%s c%0d stall", name, c), 32'(bus.stall), 32'd1);
      chk($sformatf("%s c%0d busy", name, c), 32'(bus.busy), 32'd1);
      chk($sformatf("%s c%0d done", name, c), 32'(bus.done), 32'd0);
      if (c <= 31) begin
        chk($sformatf("%s c%0d rf_en", name, c), 32'(bus.rf_wr_en), 32'd1);
        chk($sformatf("%s c%0d rf_addr", name, c), 32'(bus.rf_wr_addr), 32'(c));
        chk($sformatf("%s c%0d rf_data", name, c), bus.rf_wr_data, 32'd0);
      end else begin
`ifdef CLEAR_FP_REGS_EN
        chk($sformatf("%s c%0d rf_en", name, c), 32'(bus.rf_wr_en), 32'd0);
        chk($sformatf("%s c%0d fp_en", name, c), 32'(bus.fp_wr_en), 32'd1);
        chk($sformatf("%s c%0d fp_addr", name, c), 32'(bus.fp_wr_addr), 32'(c - 32));
        chk($sformatf("%s c%0d fp_data", name, c), bus.fp_wr_data, 32'd0);
`endif
      end
    end
    step();
    bus.start = 1'b0;
    #1;
    chk({name, " done cyc done"}, 32'(bus.done), 32'd1);
    chk({name, " done cyc busy"}, 32'(bus.busy), 32'd0);
    chk({name, " done cyc stall"}, 32'(bus.stall), 32'd0);
    chk({name, " done cyc rf_en"}, 32'(bus.rf_wr_en), 32'd0);
    bus.cpu_wr_en = 1'b0;
    step();
    chk({name, " after done"}, 32'(bus.done), 32'd0);
    chk({name, " after busy"}, 32'(bus.busy), 32'd0);
    step();
    chk({name, " after2 busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.cpu_wr_en   = 1'b0;
    bus.cpu_wr_addr = '0;
    bus.cpu_wr_data = '0;
    do_preload();
    step();
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset stall", 32'(bus.stall), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
`ifdef CLEAR_FP_REGS_EN
    chk("reset fp_en", 32'(bus.fp_wr_en), 32'd0);
`endif
    reset = 1'b0;

    // 1: idle pass-through, same cycle
    step();
    bus.cpu_wr_en = 1'b1; bus.cpu_wr_addr = 5'd5; bus.cpu_wr_data = 32'h10e;
    #1;
    chk("t1 rf_en", 32'(bus.rf_wr_en), 32'd1);
    chk("t1 rf_addr", 32'(bus.rf_wr_addr), 32'd5);
    chk("t1 rf_data", bus.rf_wr_data, 32'h10e);
    chk("t1 busy", 32'(bus.busy), 32'd0);
    chk("t1 done", 32'(bus.done), 32'd0);
    step();
    bus.cpu_wr_en = 1'b0;
    chk("t1 mem5", rf_mem[5], 32'h10e);

    // 2 (and 5 in the FP build): full clear pass
    do_preload();
    bus.start = 1'b1;
    #1;
    run_pass("t2", 1'b0);
    chk("t2 mem0", rf_mem[0], pat(0));
    for (int i = 1; i < 32; i++) chk($sformatf("t2 mem%0d", i), rf_mem[i], 32'd0);
`ifdef CLEAR_FP_REGS_EN
    for (int i = 0; i < 32; i++) chk($sformatf("t5 fp%0d", i), fp_mem[i], 32'd0);
`endif
    bus.cpu_wr_en = 1'b1; bus.cpu_wr_addr = 5'd9; bus.cpu_wr_data = 32'h55;
    #1;
    chk("t2 restore en", 32'(bus.rf_wr_en), 32'd1);
    chk("t2 restore addr", 32'(bus.rf_wr_addr), 32'd9);
    chk("t2 restore data", bus.rf_wr_data, 32'h55);
    step();
    bus.cpu_wr_en = 1'b0;

    // 3: CPU writes during clear are dropped; start mid-pass ignored
    do_preload();
    bus.start = 1'b1;
    #1;
    run_pass("t3", 1'b1);
    chk("t3 mem2", rf_mem[2], 32'd0);

    // 4: reset at clear cycle 12 aborts
    do_preload();
    bus.start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      bus.start = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("t4 reset cyc rf_en", 32'(bus.rf_wr_en), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("t4 busy", 32'(bus.busy), 32'd0);
    chk("t4 stall", 32'(bus.stall), 32'd0);
    chk("t4 rf_en idle", 32'(bus.rf_wr_en), 32'd0);
    bus.cpu_wr_en = 1'b1; bus.cpu_wr_addr = 5'd0; bus.cpu_wr_data = 32'h1;
    #1;
    chk("t4 rf_en follows", 32'(bus.rf_wr_en), 32'd1);
    step();
    bus.cpu_wr_en = 1'b0;
    for (int c = 0; c < DONE_CYC + 4; c++) begin
      chk($sformatf("t4 nodone %0d", c), 32'(bus.done), 32'd0);
      step();
    end
    for (int i = 1; i < 12; i++) chk($sformatf("t4 mem%0d", i), rf_mem[i], 32'd0);
    for (int i = 12; i < 32; i++) chk($sformatf("t4 mem%0d", i), rf_mem[i], pat(i));

    // 6: start and CPU write in the same idle cycle
    do_preload();
    bus.start = 1'b1;
    bus.cpu_wr_en = 1'b1; bus.cpu_wr_addr = 5'd3; bus.cpu_wr_data = 32'd7;
    #1;
    chk("t6 rf_en", 32'(bus.rf_wr_en), 32'd1);
    chk("t6 rf_addr", 32'(bus.rf_wr_addr), 32'd3);
    chk("t6 rf_data", bus.rf_wr_data, 32'd7);
    step();
    bus.start = 1'b0;
    bus.cpu_wr_en = 1'b0;
    #1;
    chk("t6 mem3 landed", rf_mem[3], 32'd7);
    chk("t6 first clr addr", 32'(bus.rf_wr_addr), 32'd1);
    chk("t6 busy", 32'(bus.busy), 32'd1);
    for (int c = 2; c <= DONE_CYC + 1; c++) step();
    chk("t6 mem3 cleared", rf_mem[3], 32'd0);
    chk("t6 idle", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
